oled_frame_streamer: RTL

Parametrised SSD1306-class display streamer, the successor to the fixed 128x64 controller. Runs a power-on command sequence, then streams a page-addressed frame buffer through the existing byte-level I2C master (start/DCn/Data/busy handshake). Generalised in columns, pages and column offset, with single-shot or continuous refresh. Adds a frame-done strobe and an external frame-buffer read port replacing hard-wired RAM.

---
 rtl/oled_frame_streamer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: SSD1306-class power-on init followed by page-addressed
// frame streaming through a byte-level I2C master (start/dcn/data/busy).
// Optional build macro: PARTIAL_UPDATE_EN adds a per-page dirty mask input;
// pages whose latched dirty bit is 0 are skipped (no header, no reads).
module oled_frame_streamer #(
  parameter int         COLS       = 128,
  parameter int         PAGES      = 8,
  parameter int         COL_OFS    = 0,
  parameter int         FB_AW      = 10,
  parameter int         GAP        = 5,
  parameter logic [7:0] CONTRAST   = 8'h7F,
  parameter bit         CONTINUOUS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             frame_req,
  output logic             start,
  output logic             dcn,
  output logic [7:0]       data,
  input  logic             busy,
`ifdef PARTIAL_UPDATE_EN
  input  logic [PAGES-1:0] dirty,
`endif
  output logic             fb_rd,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_data,
  output logic             frame_done,
  output logic             fps
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int GW = $clog2(GAP + 1);

  localparam logic [6:0]    OFS7      = 7'(COL_OFS);
  localparam logic [7:0]    HDR_LO    = {4'b0000, OFS7[3:0]};
  localparam logic [7:0]    HDR_HI    = {5'b00010, OFS7[6:4]};
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PAGE_HDR,
    S_FETCH,
    S_SEND,
    S_FRAME_END
  } state_t;

  state_t           state_q;
  logic [2:0]       idx_q;
  logic [PW-1:0]    page_q;
  logic [CW-1:0]    col_q;
  logic [1:0]       fetch_ph_q;
  logic [GW-1:0]    gap_q;
  logic             init_done_q;
  logic             pending_q;
  logic [7:0]       fb_byte_q;
  logic             start_q;
  logic             dcn_q;
  logic [7:0]       data_q;
  logic             fb_rd_q;
  logic [FB_AW-1:0] fb_addr_q;
  logic             frame_done_q;
  logic             fps_q;

  logic [7:0]       init_cmd_d;
  logic [7:0]       hdr_cmd_d;
  logic [FB_AW-1:0] rd_addr_d;
  logic             byte_ready;
  logic             page_dirty;

`ifdef PARTIAL_UPDATE_EN
  logic [PAGES-1:0] dirty_q;
  assign page_dirty = dirty_q[page_q];
`else
  assign page_dirty = 1'b1;
`endif

  // A new byte may only go out once the post-start gap has elapsed and the
  // I2C master reports idle; this also keeps start low whenever busy is high.
  assign byte_ready = !busy && (gap_q == '0);

  // Frame-buffer address of the next data byte: page*COLS + col.
  assign rd_addr_d = FB_AW'(page_q) * FB_AW'(COLS) + FB_AW'(col_q);

  // Power-on command table, indexed by the shared byte index.
  always_comb begin
    init_cmd_d = CONTRAST;
    case (idx_q)
      3'd0:    init_cmd_d = 8'hAF;
      3'd1:    init_cmd_d = 8'hA6;
      3'd2:    init_cmd_d = 8'h20;
      3'd3:    init_cmd_d = 8'h02;
      3'd4:    init_cmd_d = 8'h8D;
      3'd5:    init_cmd_d = 8'h14;
      3'd6:    init_cmd_d = 8'h81;
      default: init_cmd_d = CONTRAST;
    endcase
  end

  // Page header: page select, then low and high column start nibbles.
  always_comb begin
    hdr_cmd_d = HDR_HI;
    case (idx_q)
      3'd0:    hdr_cmd_d = 8'hB0 | 8'(page_q);
      3'd1:    hdr_cmd_d = HDR_LO;
      default: hdr_cmd_d = HDR_HI;
    endcase
  end

  // Main sequencer: init, per-page headers, fetch/send of data bytes, frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      page_q       <= '0;
      col_q        <= '0;
      fetch_ph_q   <= '0;
      gap_q        <= '0;
      init_done_q  <= 1'b0;
      pending_q    <= 1'b0;
      fb_byte_q    <= '0;
      start_q      <= 1'b0;
      dcn_q        <= 1'b0;
      data_q       <= '0;
      fb_rd_q      <= 1'b0;
      fb_addr_q    <= '0;
      frame_done_q <= 1'b0;
      fps_q        <= 1'b0;
`ifdef PARTIAL_UPDATE_EN
      dirty_q      <= '0;
`endif
    end else begin
      start_q      <= 1'b0;
      fb_rd_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;
      // At most one frame request is queued in single-shot mode.
      if (frame_req && !CONTINUOUS) pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            if (!init_done_q) begin
              state_q <= S_INIT;
              idx_q   <= '0;
            end else if (CONTINUOUS || pending_q) begin
              state_q   <= S_PAGE_HDR;
              page_q    <= '0;
              idx_q     <= '0;
              // A request arriving on this very cycle belongs to the next frame.
              pending_q <= frame_req && !CONTINUOUS;
`ifdef PARTIAL_UPDATE_EN
              dirty_q   <= dirty;
`endif
            end
          end
        end

        S_INIT: begin
          if (byte_ready) begin
            start_q <= 1'b1;
            dcn_q   <= 1'b0;
            data_q  <= init_cmd_d;
            gap_q   <= GW'(GAP);
            if (idx_q == 3'd7) begin
              init_done_q <= 1'b1;
              state_q     <= S_PAGE_HDR;
              page_q      <= '0;
              idx_q       <= '0;
`ifdef PARTIAL_UPDATE_EN
              dirty_q     <= dirty;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end

        S_PAGE_HDR: begin
          if (!page_dirty) begin
            // Clean page: skip it without touching the bus or the buffer.
            if (page_q == LAST_PAGE) state_q <= S_FRAME_END;
            else                     page_q  <= page_q + PW'(1);
          end else if (byte_ready) begin
            start_q <= 1'b1;
            dcn_q   <= 1'b0;
            data_q  <= hdr_cmd_d;
            gap_q   <= GW'(GAP);
            if (idx_q == 3'd2) begin
              state_q    <= S_FETCH;
              col_q      <= '0;
              fetch_ph_q <= '0;
              idx_q      <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end

        S_FETCH: begin
          // Prefetch into a side register so data stays stable while the
          // previous byte is still on the wire.
          case (fetch_ph_q)
            2'd0: begin
              fb_rd_q    <= 1'b1;
              fb_addr_q  <= rd_addr_d;
              fetch_ph_q <= 2'd1;
            end
            2'd1: fetch_ph_q <= 2'd2;
            default: begin
              fb_byte_q  <= fb_data;
              fetch_ph_q <= 2'd0;
              state_q    <= S_SEND;
            end
          endcase
        end

        S_SEND: begin
          if (byte_ready) begin
            start_q <= 1'b1;
            dcn_q   <= 1'b1;
            data_q  <= fb_byte_q;
            gap_q   <= GW'(GAP);
            if (col_q == LAST_COL) begin
              if (page_q == LAST_PAGE) begin
                state_q <= S_FRAME_END;
              end else begin
                page_q  <= page_q + PW'(1);
                idx_q   <= '0;
                state_q <= S_PAGE_HDR;
              end
            end else begin
              col_q   <= col_q + CW'(1);
              state_q <= S_FETCH;
            end
          end
        end

        S_FRAME_END: begin
          frame_done_q <= 1'b1;
          fps_q        <= ~fps_q;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start      = start_q;
  assign dcn        = dcn_q;
  assign data       = data_q;
  assign fb_rd      = fb_rd_q;
  assign fb_addr    = fb_addr_q;
  assign frame_done = frame_done_q;
  assign fps        = fps_q;

endmodule
